// File: rtl/fighter_pkg.sv
// Shared game-logic definitions: vertical motion states, screen geometry,
// and a saturating helper that maps a signed position onto the 7-bit screen.
package fighter_pkg;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } vstate_t;

    localparam int unsigned SCREEN_W = 96;
    localparam int unsigned SPRITE_W = 16;
    localparam int unsigned GROUND_Y = 40;

    // Saturate a signed 9-bit coordinate into [0, hi].
    function automatic logic [6:0] clamp_pos(input logic signed [8:0] v,
                                             input logic signed [8:0] hi);
        logic [6:0] r;
        if (v < 9'sd0) begin
            r = '0;
        end else if (v > hi) begin
            r = hi[6:0];
        end else begin
            r = v[6:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running divider that pulses tick for one clk cycle every TICK_DIV cycles.
module frame_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/fighter_motion_ctrl.sv
// Per-fighter motion controller: walking with wall and gap limits, jump with
// gravity, and hit knockback, all advanced once per frame tick.
module fighter_motion_ctrl #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int SCREEN_W  = fighter_pkg::SCREEN_W,
    parameter int SPRITE_W  = fighter_pkg::SPRITE_W,
    parameter int GROUND_Y  = fighter_pkg::GROUND_Y,
    parameter int START_X   = 10,
    parameter int WALK_STEP = 1,
    parameter int JUMP_V0   = 6,
    parameter int GRAVITY   = 1,
    parameter int MIN_GAP   = 16,
    parameter int KB_STEP   = 2,
    parameter int KB_TICKS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       hit,
    input  logic       facing_right,
    input  logic [6:0] other_x,
    output logic [6:0] sprite_x,
    output logic [6:0] sprite_y,
    output logic       airborne,
    output logic       in_knockback
);

    import fighter_pkg::vstate_t;
    import fighter_pkg::GROUND;
    import fighter_pkg::AIR;
    import fighter_pkg::clamp_pos;

    localparam int unsigned KW = (KB_TICKS > 0) ? $clog2(KB_TICKS + 1) : 1;

    localparam logic signed [8:0] XMAX    = 9'(SCREEN_W - SPRITE_W);
    localparam logic signed [8:0] YMAX    = 9'sd127;
    localparam logic signed [8:0] GY      = 9'(GROUND_Y);
    localparam logic signed [8:0] WALK_D  = 9'(WALK_STEP);
    localparam logic signed [8:0] KB_D    = 9'(KB_STEP);
    localparam logic signed [8:0] GAP_D   = 9'(MIN_GAP);
    localparam logic signed [5:0] VY_G    = 6'(GRAVITY);
    localparam logic signed [5:0] VY_JUMP = 6'(GRAVITY - JUMP_V0);

    logic                 tick;
    vstate_t              vst_q, vst_nx;
    logic signed [5:0]    vy_q, vy_nx;
    logic [KW-1:0]        kb_q, kb_eff, kb_nx;
    logic                 hit_pend_q;
    logic                 hit_now;
    logic [6:0]           x_nx, y_nx, step_x;
    logic signed [8:0]    xs, os, ys, cand, step_s, ny;
    logic                 blocked;

    frame_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Next horizontal position: knockback overrides walking.
    always_comb begin
        hit_now = hit | hit_pend_q;
        xs      = $signed({2'b00, sprite_x});
        os      = $signed({2'b00, other_x});
        kb_eff  = hit_now ? KW'(KB_TICKS) : kb_q;
        kb_nx   = kb_eff;
        x_nx    = sprite_x;
        cand    = '0;
        step_x  = '0;
        step_s  = '0;
        blocked = 1'b0;
        if (kb_eff != '0) begin
            cand  = facing_right ? (xs - KB_D) : (xs + KB_D);
            x_nx  = clamp_pos(cand, XMAX);
            kb_nx = kb_eff - KW'(1);
        end else if (btn_left ^ btn_right) begin
            cand    = btn_right ? (xs + WALK_D) : (xs - WALK_D);
            step_x  = clamp_pos(cand, XMAX);
            step_s  = $signed({2'b00, step_x});
            blocked = btn_right ? ((os > xs) && (step_s > (os - GAP_D)))
                                : ((os < xs) && (step_s < (os + GAP_D)));
            if (!blocked) begin
                x_nx = step_x;
            end
        end
    end

    // Next vertical state: jump launch from ground, ballistic arc in the air.
    always_comb begin
        ys     = $signed({2'b00, sprite_y});
        ny     = '0;
        vst_nx = vst_q;
        y_nx   = sprite_y;
        vy_nx  = vy_q;
        if (vst_q == GROUND) begin
            if (btn_jump) begin
                y_nx   = 7'(GROUND_Y - JUMP_V0);
                vy_nx  = VY_JUMP;
                vst_nx = AIR;
            end
        end else begin
            ny = ys + $signed({{3{vy_q[5]}}, vy_q});
            if (ny >= GY) begin
                y_nx   = 7'(GROUND_Y);
                vy_nx  = '0;
                vst_nx = GROUND;
            end else begin
                y_nx  = clamp_pos(ny, YMAX);
                vy_nx = vy_q + VY_G;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sprite_x     <= 7'(START_X);
            sprite_y     <= 7'(GROUND_Y);
            vy_q         <= '0;
            vst_q        <= GROUND;
            kb_q         <= '0;
            hit_pend_q   <= 1'b0;
            airborne     <= 1'b0;
            in_knockback <= 1'b0;
        end else if (tick) begin
            sprite_x     <= x_nx;
            sprite_y     <= y_nx;
            vy_q         <= vy_nx;
            vst_q        <= vst_nx;
            kb_q         <= kb_nx;
            hit_pend_q   <= 1'b0;
            airborne     <= (vst_nx == AIR);
            in_knockback <= (kb_nx != '0);
        end else if (hit) begin
            hit_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// Bench for fighter_motion_ctrl: directed vector table, corner sequences and
// random stimulus against a closed-form motion model.
module tb_fighter_motion_ctrl;

    localparam int TDIV = 4;
    localparam int XMAX = 80;
    localparam int GY   = 40;
    localparam int V0   = 6;
    localparam int G    = 1;
    localparam int GAP  = 16;
    localparam int KBS  = 2;
    localparam int KBT  = 4;
    localparam int X0   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_jump, hit, facing_right;
    logic [6:0] other_x;
    logic [6:0] sprite_x, sprite_y;
    logic       airborne, in_knockback;

    int total = 0;
    int bad   = 0;
    int cyc;
    int m_x, m_y, m_k, m_kb;
    bit m_pend;

    typedef struct {
        bit l, r, j, h, f;
        int ex, ey;
        bit eair, ekb;
    } vec_t;

    vec_t tbl[15];
    int   kbx[7];

    fighter_motion_ctrl #(
        .TICK_DIV (TDIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .hit          (hit),
        .facing_right (facing_right),
        .other_x      (other_x),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .airborne     (airborne),
        .in_knockback (in_knockback)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Height above ground k ticks into a jump.
    function automatic int height(input int k);
        return V0 * k - (G * k * (k - 1)) / 2;
    endfunction

    task automatic model_reset();
        m_x = X0; m_y = GY; m_k = 0; m_kb = 0; m_pend = 0; cyc = 0;
    endtask

    task automatic model_tick(input bit h);
        int c, o;
        bit ok;
        o = int'(other_x);
        if (h) m_kb = KBT;
        if (m_kb > 0) begin
            m_x = clampi(m_x + (facing_right ? -KBS : KBS), 0, XMAX);
            m_kb--;
        end else if (btn_left != btn_right) begin
            c  = clampi(m_x + (btn_right ? 1 : -1), 0, XMAX);
            ok = 1;
            if (btn_right && o > m_x && c > o - GAP) ok = 0;
            if (btn_left  && o < m_x && c < o + GAP) ok = 0;
            if (ok) m_x = c;
        end
        if (m_k == 0) begin
            if (btn_jump) m_k = 1;
        end else begin
            m_k++;
        end
        if (m_k > 0) begin
            m_y = GY - height(m_k);
            if (m_y >= GY) begin
                m_y = GY;
                m_k = 0;
            end else if (m_y < 0) begin
                m_y = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (cyc % TDIV == 0) begin
            model_tick(hit | m_pend);
            m_pend = 0;
        end else if (hit) begin
            m_pend = 1;
        end
        #1;
        check("cyc_x",   sprite_x,     m_x);
        check("cyc_y",   sprite_y,     m_y);
        check("cyc_air", airborne,     m_k > 0);
        check("cyc_kb",  in_knockback, m_kb > 0);
    endtask

    task automatic run_ticks(input int n);
        repeat (n * TDIV) cycle();
    endtask

    task automatic hit_tick();
        hit = 1'b1;
        cycle();
        hit = 1'b0;
        repeat (TDIV - 1) cycle();
    endtask

    task automatic clear_inputs();
        btn_left = 0; btn_right = 0; btn_jump = 0; hit = 0; facing_right = 0; other_x = '0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_x",   sprite_x,     X0);
        check("rst_y",   sprite_y,     GY);
        check("rst_air", airborne,     0);
        check("rst_kb",  in_knockback, 0);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tbl[0]  = '{0,0,1,0,0, 10,34,1,0};
        tbl[1]  = '{0,1,0,0,0, 11,29,1,0};
        tbl[2]  = '{0,1,0,0,0, 12,25,1,0};
        tbl[3]  = '{0,0,0,0,0, 12,22,1,0};
        tbl[4]  = '{1,1,0,0,0, 12,20,1,0};
        tbl[5]  = '{1,0,0,0,0, 11,19,1,0};
        tbl[6]  = '{0,0,0,0,0, 11,19,1,0};
        tbl[7]  = '{0,0,0,1,1,  9,20,1,1};
        tbl[8]  = '{0,1,0,0,1,  7,22,1,1};
        tbl[9]  = '{0,1,0,0,1,  5,25,1,1};
        tbl[10] = '{0,1,0,0,1,  3,29,1,0};
        tbl[11] = '{0,0,0,0,0,  3,34,1,0};
        tbl[12] = '{0,0,1,0,0,  3,40,0,0};
        tbl[13] = '{0,0,1,0,0,  3,34,1,0};
        tbl[14] = '{0,0,0,0,0,  3,29,1,0};
        kbx = '{38, 36, 34, 32, 30, 28, 29};

        #2;
        check("init_x",   sprite_x, X0);
        check("init_y",   sprite_y, GY);
        check("init_air", airborne, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Directed table: jump arc, airborne walking, knockback, re-jump on landing.
        other_x = 7'd100;
        for (int i = 0; i < 15; i++) begin
            btn_left = tbl[i].l; btn_right = tbl[i].r; btn_jump = tbl[i].j;
            facing_right = tbl[i].f; hit = tbl[i].h;
            cycle();
            hit = 1'b0;
            repeat (TDIV - 1) cycle();
            check($sformatf("tbl%0d_x", i),   sprite_x,     tbl[i].ex);
            check($sformatf("tbl%0d_y", i),   sprite_y,     tbl[i].ey);
            check($sformatf("tbl%0d_air", i), airborne,     tbl[i].eair);
            check($sformatf("tbl%0d_kb", i),  in_knockback, tbl[i].ekb);
        end

        // Walk into the right wall, then both buttons held.
        do_reset();
        btn_right = 1;
        run_ticks(75);
        check("wall_x", sprite_x, 80);
        btn_left = 1;
        run_ticks(2);
        check("both_x", sprite_x, 80);

        // Gap rule in both directions.
        do_reset();
        btn_right = 1;
        run_ticks(20);
        check("gap_pre_x", sprite_x, 30);
        other_x = 7'd47;
        run_ticks(1);
        check("gap_step_x", sprite_x, 31);
        run_ticks(1);
        check("gap_hold_x", sprite_x, 31);
        btn_right = 0; btn_left = 1; other_x = 7'd10;
        run_ticks(6);
        check("gap_left_x", sprite_x, 26);

        // Knockback with restart, walking input ignored until it expires.
        do_reset();
        btn_right = 1;
        run_ticks(30);
        check("kb_pre_x", sprite_x, 40);
        facing_right = 1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 2) hit_tick();
            else run_ticks(1);
            check($sformatf("kb%0d_x", i),  sprite_x,     kbx[i]);
            check($sformatf("kb%0d_on", i), in_knockback, i < 5);
        end

        // Knockback clamps at the left wall.
        do_reset();
        other_x = 7'd127; btn_left = 1;
        run_ticks(9);
        check("kbw_pre_x", sprite_x, 1);
        btn_left = 0; facing_right = 1;
        hit_tick();
        check("kbw0_x", sprite_x, 0);
        run_ticks(3);
        check("kbw3_x", sprite_x, 0);
        check("kbw3_on", in_knockback, 0);

        // Hit and jump arriving on the tick cycle itself.
        do_reset();
        other_x = 7'd100;
        repeat (TDIV - 1) cycle();
        hit = 1; btn_jump = 1;
        cycle();
        hit = 0; btn_jump = 0;
        check("sim_x",   sprite_x,     12);
        check("sim_y",   sprite_y,     34);
        check("sim_air", airborne,     1);
        check("sim_kb",  in_knockback, 1);

        // Random stimulus, inputs changing every cycle, with one reset in the middle.
        for (int n = 0; n < 1600; n++) begin
            if (n == 800) do_reset();
            btn_left     = 1'($urandom_range(0, 1));
            btn_right    = 1'($urandom_range(0, 1));
            btn_jump     = ($urandom_range(0, 3) == 0);
            facing_right = 1'($urandom_range(0, 1));
            hit          = ($urandom_range(0, 15) == 0);
            if (n % 16 == 0) other_x = 7'($urandom_range(0, 127));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
